// File: rtl/reg_wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Source encoding, default widths and the queue entry layout.
package reg_wb_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 32;

   localparam logic SRC_A = 1'b0;
   localparam logic SRC_B = 1'b1;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

   // Room for both queues full plus the write sitting in the output stage.
   function automatic int cnt_width(input int depth);
      return $clog2(2 * depth + 2);
   endfunction

endpackage

// File: rtl/reg_wb_if.sv
// Writeback bus: two request sources, the register-file write port
// and the per-register busy vector used for hazard detection.
interface reg_wb_if #(
   parameter int DATA_W = reg_wb_pkg::DATA_W,
   parameter int ADDR_W = reg_wb_pkg::ADDR_W
);
   import reg_wb_pkg::*;

   logic              a_valid;
   logic              a_ready;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_data;

   logic              b_valid;
   logic              b_ready;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_data;

   logic              wren;
   logic [ADDR_W-1:0] wr;
   logic [DATA_W-1:0] wd;

   logic [NUM_REGS-1:0] busy;

   modport master (
      output a_valid, a_addr, a_data,
      output b_valid, b_addr, b_data,
      input  a_ready, b_ready,
      input  wren, wr, wd, busy
   );

   modport slave (
      input  a_valid, a_addr, a_data,
      input  b_valid, b_addr, b_data,
      output a_ready, b_ready,
      output wren, wr, wd, busy
   );

endinterface

// File: rtl/reg_wb_arbiter_fifo.sv
// Small synchronous FIFO holding pending writes of one source.
// Head is valid whenever empty is low; push when full is ignored.
module wb_fifo #(
   parameter int W     = 37,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] head,
   output logic         full,
   output logic         empty
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [PW-1:0] wp;
   logic [PW-1:0] rp;
   logic [PW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rp];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wp] <= din;
      end
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (do_push) begin
            wp <= wp + 1'b1;
         end
         if (do_pop) begin
            rp <= rp + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Round-robin writeback arbiter with per-source queues and a
// pending-write scoreboard exported as a busy vector.
module reg_wb_arbiter #(
   parameter int DATA_W = reg_wb_pkg::DATA_W,
   parameter int ADDR_W = reg_wb_pkg::ADDR_W,
   parameter int DEPTH  = 2
) (
   input  logic     clk,
   input  logic     rst,
   reg_wb_if.slave  bus
);
   import reg_wb_pkg::*;

   localparam int EW = ADDR_W + DATA_W;
   localparam int CW = cnt_width(DEPTH);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } entry_t;

   entry_t a_in;
   entry_t b_in;
   entry_t a_head;
   entry_t b_head;

   logic a_full;
   logic a_empty;
   logic b_full;
   logic b_empty;
   logic a_push;
   logic b_push;
   logic a_pop;
   logic b_pop;

   logic              last_grant;
   logic              wren_q;
   logic [ADDR_W-1:0] wr_q;
   logic [DATA_W-1:0] wd_q;

   logic [CW-1:0]       cnt [NUM_REGS];
   logic [NUM_REGS-1:0] a_hit;
   logic [NUM_REGS-1:0] b_hit;
   logic [NUM_REGS-1:0] c_hit;
   logic [NUM_REGS-1:0] busy_v;

   assign bus.a_ready = !a_full;
   assign bus.b_ready = !b_full;
   assign bus.wren    = wren_q;
   assign bus.wr      = wr_q;
   assign bus.wd      = wd_q;
   assign bus.busy    = busy_v;

   // Writes to x0 complete the handshake but are never queued.
   assign a_push = bus.a_valid && !a_full && (bus.a_addr != '0);
   assign b_push = bus.b_valid && !b_full && (bus.b_addr != '0);
   assign a_in   = {bus.a_addr, bus.a_data};
   assign b_in   = {bus.b_addr, bus.b_data};

   wb_fifo #(.W(EW), .DEPTH(DEPTH)) u_a_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (a_push),
      .pop   (a_pop),
      .din   (a_in),
      .head  (a_head),
      .full  (a_full),
      .empty (a_empty)
   );

   wb_fifo #(.W(EW), .DEPTH(DEPTH)) u_b_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (b_push),
      .pop   (b_pop),
      .din   (b_in),
      .head  (b_head),
      .full  (b_full),
      .empty (b_empty)
   );

   always_comb begin
      a_pop = 1'b0;
      b_pop = 1'b0;
      if (!a_empty && (b_empty || last_grant == SRC_B)) begin
         a_pop = 1'b1;
      end else if (!b_empty) begin
         b_pop = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wren_q     <= 1'b0;
         wr_q       <= '0;
         wd_q       <= '0;
         last_grant <= SRC_B;
      end else begin
         wren_q <= a_pop | b_pop;
         if (a_pop) begin
            wr_q       <= a_head.addr;
            wd_q       <= a_head.data;
            last_grant <= SRC_A;
         end else if (b_pop) begin
            wr_q       <= b_head.addr;
            wd_q       <= b_head.data;
            last_grant <= SRC_B;
         end
      end
   end

   // A register stays busy from acceptance until reg_file captures it.
   always_comb begin
      a_hit = '0;
      b_hit = '0;
      c_hit = '0;
      if (a_push) begin
         a_hit = NUM_REGS'(1) << bus.a_addr;
      end
      if (b_push) begin
         b_hit = NUM_REGS'(1) << bus.b_addr;
      end
      if (wren_q) begin
         c_hit = NUM_REGS'(1) << wr_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            cnt[r] <= '0;
         end
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            cnt[r] <= cnt[r] + CW'(a_hit[r]) + CW'(b_hit[r])
                    - CW'(c_hit[r]);
         end
      end
   end

   always_comb begin
      busy_v = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         busy_v[r] = (cnt[r] != '0);
      end
   end

endmodule
